uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Sequences one uart_rx instance and assembles its byte stream into validated command frames.
- Frame format on the wire: SOF, CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of CMD, LEN and every payload byte.
- Drives the uart_rx enable and consumes its data/done/error outputs. Presents a completed frame to the host logic through a valid/ack handshake with a random-access payload read port.
- Runs on the same baud (16x oversample) clock as uart_rx.

Parameters:
- NUM_DATA_BITS, 8, byte width; must equal the uart global setting.
- MAX_PAYLOAD, 16, payload buffer depth in bytes (1..255).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_TICKS, 704, baud ticks allowed between bytes inside a frame (4 char times at 16x, 11 bits).

Ports:
- baud, in, 1, oversample clock shared with uart_rx.
- rst_n, in, 1, asynchronous active-low reset.
- rx_enable, out, 1, drives uart_rx enable.
- rx_data, in, NUM_DATA_BITS, uart_rx data.
- rx_done, in, 1, uart_rx done level.
- rx_busy, in, 1, uart_rx busy.
- rx_error, in, 1, uart_rx error level.
- cmd_valid, out, 1, completed frame held for host.
- cmd_code, out, 8, CMD byte of held frame.
- cmd_len, out, $clog2(MAX_PAYLOAD+1), payload length of held frame.
- pl_addr, in, $clog2(MAX_PAYLOAD), payload read index.
- pl_data, out, 8, payload byte at pl_addr (combinational read).
- cmd_ack, in, 1, host releases held frame.
- err_chk, out, 1, one-cycle pulse: checksum mismatch.
- err_len, out, 1, one-cycle pulse: LEN > MAX_PAYLOAD.
- err_line, out, 1, one-cycle pulse: uart_rx error edge during a frame.
- err_timeout, out, 1, one-cycle pulse: inter-byte timeout.
- drop_count, out, 8, saturating count of aborted or overrun frames.

Behaviour:
Reset and events
- On reset, all outputs are 0 and state is IDLE. rx_enable is 0 during reset and 1 from the first clock after release.
- done_q and err_q register rx_done and rx_error.
- byte_evt = rx_done & ~done_q; err_evt = rx_error & ~err_q. These are combinational and the FSM acts on them in the same cycle. All outputs are registered, so a response appears one cycle after the event.
- err_evt has priority over byte_evt in the same cycle.

FSM states: IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD
- IDLE: byte_evt with rx_data==SOF_BYTE goes to CMD. Any other byte is ignored silently.
- CMD: byte_evt latches cmd_code, sets chk=byte and goes to LEN.
- LEN: byte_evt with byte > MAX_PAYLOAD: err_len pulse, drop_count+1, rx_enable low one cycle, go to IDLE. Otherwise latch cmd_len, chk^=byte, clear idx. Next state is CHECK if byte==0, else PAYLOAD.
- PAYLOAD: byte_evt writes buf[idx], chk^=byte, idx+1. Goes to CHECK when idx==cmd_len-1.
- CHECK: byte_evt with byte==chk goes to HOLD and sets cmd_valid=1. Otherwise err_chk pulse, drop_count+1, go to IDLE.
- HOLD: cmd_valid, cmd_code, cmd_len and the buffer stay stable.
  - cmd_ack clears cmd_valid next cycle and goes to IDLE.
  - A byte_evt without cmd_ack is an overrun: drop_count+1, stay in HOLD.
  - cmd_ack together with byte_evt: ack wins, and the byte is evaluated as in IDLE (SOF goes straight to CMD).
  - cmd_ack outside HOLD is ignored.

Timeout and abort
- Timer clears on byte_evt and counts only in CMD, LEN, PAYLOAD and CHECK.
- At TIMEOUT_TICKS-1: err_timeout pulse, drop_count+1, rx_enable low one cycle, go to IDLE.
- err_evt in CMD through CHECK: err_line pulse, drop_count+1, rx_enable low one cycle, go to IDLE.
- err_evt in IDLE or HOLD is ignored; no count.

Other rules
- drop_count saturates at 8'hFF.
- pl_data for pl_addr >= cmd_len is don't-care.
- Asynchronous reset mid-frame discards everything.

Decomposition:
- A shared package uart_ctrl_pkg holds the state enum, SOF_BYTE default and the timeout width function. The uart_globals include stays the source of NUM_DATA_BITS.
- One natural sub-module: uart_frame_buf, a MAX_PAYLOAD x 8 register file with a synchronous write and a combinational read.

Test Plan:
1. Good frame: A5 10 02 33 44 65 -> cmd_valid=1, cmd_code=0x10, cmd_len=2, pl[0]=0x33, pl[1]=0x44. After cmd_ack, cmd_valid=0 next cycle.
2. Bad checksum: A5 10 02 33 44 66 -> err_chk pulse, drop_count=1, no cmd_valid.
3. Bad length: LEN=0x11 with MAX_PAYLOAD 16 -> err_len pulse, rx_enable low exactly one cycle. A following good frame is accepted.
4. Zero length: A5 07 00 07 -> cmd_valid with cmd_len=0.
5. Timeout: A5 10 then line idle for 704 ticks -> err_timeout pulse, state returns to IDLE, drop_count increments.
6. Overrun and ack race: second frame arrives while HOLD -> drop_count increments on each byte. cmd_ack coinciding with an A5 byte -> next frame is parsed from CMD.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART receive-side frame controller.
//   - UART_NUM_DATA_BITS : global UART character width
//   - SOF_BYTE_DEFAULT   : default start-of-frame marker
//   - frame_state_e      : frame parser states
//   - timer_width()      : width of a counter that must reach ticks-1
//   - index_width()      : width of an index into a buffer of given depth
package uart_ctrl_pkg;

  localparam int UART_NUM_DATA_BITS = 8;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } frame_state_e;

  // Bits needed to count 0..ticks-1 (never narrower than one bit).
  function automatic int timer_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  // Bits needed to address depth entries (never narrower than one bit).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame controller: DEPTH x 8 register file.
// Ports:
//   clk   - clock
//   we    - write enable (synchronous write)
//   waddr - write index
//   wdata - write byte
//   raddr - read index
//   rdata - read byte (combinational; 0 for indices beyond DEPTH)
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; contents are only meaningful
  // below the held frame's length, which is always written first.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences one uart_rx instance and assembles its byte stream into
// validated command frames: SOF, CMD, LEN, LEN payload bytes, CHK, where
// CHK is the XOR of CMD, LEN and every payload byte.
// Ports:
//   baud        - 16x oversample clock shared with uart_rx
//   rst_n       - asynchronous active-low reset
//   rx_enable   - uart_rx enable; dropped for one cycle after an abort
//   rx_data     - received character from uart_rx
//   rx_done     - uart_rx done level (rising edge = new byte)
//   rx_busy     - uart_rx busy (not needed by this controller)
//   rx_error    - uart_rx error level (rising edge = line error)
//   cmd_valid   - a validated frame is held for the host
//   cmd_code    - CMD byte of the held frame
//   cmd_len     - payload length of the held frame
//   pl_addr     - payload read index
//   pl_data     - payload byte at pl_addr (combinational)
//   cmd_ack     - host releases the held frame
//   err_chk     - pulse: checksum mismatch
//   err_len     - pulse: LEN larger than MAX_PAYLOAD
//   err_line    - pulse: line error inside a frame
//   err_timeout - pulse: inter-byte timeout inside a frame
//   drop_count  - saturating count of aborted or overrun frames
module uart_rx_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int         NUM_DATA_BITS = UART_NUM_DATA_BITS,
  parameter int         MAX_PAYLOAD   = 16,
  parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT,
  parameter int         TIMEOUT_TICKS = 704,
  localparam int        LW            = $clog2(MAX_PAYLOAD + 1),
  localparam int        AW            = index_width(MAX_PAYLOAD)
) (
  input  logic                     baud,
  input  logic                     rst_n,
  output logic                     rx_enable,
  input  logic [NUM_DATA_BITS-1:0] rx_data,
  input  logic                     rx_done,
  input  logic                     rx_busy,
  input  logic                     rx_error,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_code,
  output logic [LW-1:0]            cmd_len,
  input  logic [AW-1:0]            pl_addr,
  output logic [7:0]               pl_data,
  input  logic                     cmd_ack,
  output logic                     err_chk,
  output logic                     err_len,
  output logic                     err_line,
  output logic                     err_timeout,
  output logic [7:0]               drop_count
);

  localparam int TW = timer_width(TIMEOUT_TICKS);

  // Protocol bytes are 8 bits wide; the UART width is expected to match.
  logic [7:0] rx_byte;
  assign rx_byte = rx_data[7:0];

  // rx_busy carries no information the controller needs.
  logic unused_inputs;
  assign unused_inputs = rx_busy;

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  frame_state_e  state_q, state_d;
  logic          done_q, err_q;
  logic [7:0]    chk_q, chk_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    code_d;
  logic [LW-1:0] len_d;
  logic [7:0]    drop_d;

  // ---------------------------------------------------------------------
  // Edge events from the uart_rx level outputs
  // ---------------------------------------------------------------------
  logic byte_evt, err_evt;
  assign byte_evt = rx_done  & ~done_q;
  assign err_evt  = rx_error & ~err_q;

  logic in_frame, timer_hit;
  assign in_frame  = (state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK});
  assign timer_hit = (timer_q == TW'(TIMEOUT_TICKS - 1));

  // Per-cycle decision flags
  logic buf_we;
  logic chk_fail, len_fail, line_fail, tmo_fail, overrun;
  logic abort, drop_inc;

  // ---------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    code_d    = cmd_code;
    len_d     = cmd_len;
    buf_we    = 1'b0;
    chk_fail  = 1'b0;
    len_fail  = 1'b0;
    line_fail = 1'b0;
    tmo_fail  = 1'b0;
    overrun   = 1'b0;

    if (in_frame && err_evt) begin
      // Line error beats any byte arriving in the same cycle.
      line_fail = 1'b1;
      state_d   = ST_IDLE;
    end else if (in_frame && !byte_evt && timer_hit) begin
      tmo_fail = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_evt && (rx_byte == SOF_BYTE)) state_d = ST_CMD;
        end

        ST_CMD: begin
          if (byte_evt) begin
            code_d  = rx_byte;
            chk_d   = rx_byte;
            state_d = ST_LEN;
          end
        end

        ST_LEN: begin
          if (byte_evt) begin
            if (int'(rx_byte) > MAX_PAYLOAD) begin
              len_fail = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              len_d   = LW'(rx_byte);
              chk_d   = chk_q ^ rx_byte;
              idx_d   = '0;
              state_d = (rx_byte == 8'h00) ? ST_CHECK : ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (byte_evt) begin
            buf_we = 1'b1;
            chk_d  = chk_q ^ rx_byte;
            idx_d  = idx_q + AW'(1);
            if (int'(idx_q) == int'(cmd_len) - 1) state_d = ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (byte_evt) begin
            if (rx_byte == chk_q) begin
              state_d = ST_HOLD;
            end else begin
              chk_fail = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end

        ST_HOLD: begin
          if (cmd_ack) begin
            // The acknowledge wins; a coincident byte is judged as in IDLE.
            state_d = (byte_evt && (rx_byte == SOF_BYTE)) ? ST_CMD : ST_IDLE;
          end else if (byte_evt) begin
            overrun = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    abort    = line_fail | tmo_fail | len_fail;
    drop_inc = abort | chk_fail | overrun;
    drop_d   = (drop_inc && (drop_count != 8'hFF)) ? drop_count + 8'd1 : drop_count;

    // Timer restarts on every byte and only runs while a frame is open.
    if (byte_evt || !(state_d inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK})) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every register samples the pre-edge values computed above.
  always_ff @(posedge baud or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      chk_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      rx_enable   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_len     <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_line    <= 1'b0;
      err_timeout <= 1'b0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= rx_done;
      err_q       <= rx_error;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      rx_enable   <= ~abort;
      cmd_valid   <= (state_d == ST_HOLD);
      cmd_code    <= code_d;
      cmd_len     <= len_d;
      err_chk     <= chk_fail;
      err_len     <= len_fail;
      err_line    <= line_fail;
      err_timeout <= tmo_fail;
      drop_count  <= drop_d;
    end
  end

  // ---------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------
  uart_frame_buf #(
    .DEPTH(MAX_PAYLOAD),
    .AW   (AW)
  ) u_buf (
    .clk  (baud),
    .we   (buf_we),
    .waddr(idx_q),
    .wdata(rx_byte),
    .raddr(pl_addr),
    .rdata(pl_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl. A byte-stream reference model
// collects bytes into a queue, judges whole frames by length and XOR, and
// predicts held frames, error pulse counts, rx_enable drops and drop_count.
module tb_uart_rx_frame_ctrl;

  localparam int         MAXP = 16;
  localparam int         TMO  = 704;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       baud = 1'b0;
  logic       rst_n;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, rx_error;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [4:0] cmd_len;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic       cmd_ack;
  logic       err_chk, err_len, err_line, err_timeout;
  logic [7:0] drop_count;

  always #5 baud = ~baud;

  uart_rx_frame_ctrl #(
    .NUM_DATA_BITS(8),
    .MAX_PAYLOAD  (MAXP),
    .SOF_BYTE     (SOF),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .baud       (baud),
    .rst_n      (rst_n),
    .rx_enable  (rx_enable),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .rx_error   (rx_error),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_len    (cmd_len),
    .pl_addr    (pl_addr),
    .pl_data    (pl_data),
    .cmd_ack    (cmd_ack),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_line   (err_line),
    .err_timeout(err_timeout),
    .drop_count (drop_count)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Output monitor: counts pulses and rx_enable low cycles
  // ---------------------------------------------------------------------
  bit mon_on = 1'b0;
  int mon_chk, mon_len, mon_line, mon_tmo, mon_en_low;

  always @(negedge baud) begin
    if (mon_on) begin
      if (err_chk)     mon_chk++;
      if (err_len)     mon_len++;
      if (err_line)    mon_line++;
      if (err_timeout) mon_tmo++;
      if (!rx_enable)  mon_en_low++;
    end
  end

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  bit         m_hold;
  logic [7:0] m_code;
  int         m_len;
  logic [7:0] m_pl [MAXP];
  int         m_drop;
  int         e_chk, e_len, e_line, e_tmo;
  logic [7:0] cur [$];

  task automatic model_reset();
    m_hold = 0; m_code = 0; m_len = 0; m_drop = 0;
    e_chk = 0; e_len = 0; e_line = 0; e_tmo = 0;
    mon_chk = 0; mon_len = 0; mon_line = 0; mon_tmo = 0; mon_en_low = 0;
    cur.delete();
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0] x;
    if (m_hold) begin
      bump_drop();
      return;
    end
    if (cur.size() == 0) begin
      if (b == SOF) cur.push_back(b);
      return;
    end
    cur.push_back(b);
    if (cur.size() == 3 && int'(b) > MAXP) begin
      e_len++;
      bump_drop();
      cur.delete();
      return;
    end
    if (cur.size() >= 3) begin
      n = int'(cur[2]);
      if (cur.size() == n + 4) begin
        x = 8'h00;
        for (int i = 1; i <= n + 2; i++) x ^= cur[i];
        if (x == b) begin
          m_hold = 1;
          m_code = cur[1];
          m_len  = n;
          for (int i = 0; i < n; i++) m_pl[i] = cur[3 + i];
        end else begin
          e_chk++;
          bump_drop();
        end
        cur.delete();
      end
    end
  endtask

  // Abort of an open frame (line error or timeout).
  task automatic model_abort(input bit is_line);
    if (cur.size() > 0) begin
      if (is_line) e_line++; else e_tmo++;
      bump_drop();
      cur.delete();
    end
  endtask

  // ---------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge baud);
  endtask

  task automatic send(input logic [7:0] b, input bit with_ack);
    @(negedge baud);
    rx_data = b;
    rx_done = 1'b1;
    cmd_ack = with_ack;
    if (with_ack) m_hold = 0;
    @(negedge baud);
    rx_done = 1'b0;
    cmd_ack = 1'b0;
    model_byte(b);
    idle(1 + $urandom_range(0, 3));
  endtask

  task automatic ack();
    bit was_hold;
    was_hold = m_hold;
    @(negedge baud);
    cmd_ack = 1'b1;
    @(negedge baud);
    cmd_ack = 1'b0;
    m_hold  = 0;
    if (was_hold) check("valid_clear_after_ack", 32'(cmd_valid), 32'd0);
    idle(1);
  endtask

  task automatic line_err();
    @(negedge baud);
    rx_error = 1'b1;
    @(negedge baud);
    rx_error = 1'b0;
    model_abort(1'b1);
    idle(2);
  endtask

  task automatic verify(input string tag);
    check({tag, ":valid"}, 32'(cmd_valid), 32'(m_hold));
    if (m_hold) begin
      check({tag, ":code"}, 32'(cmd_code), 32'(m_code));
      check({tag, ":len"},  32'(cmd_len),  32'(m_len));
      for (int i = 0; i < m_len; i++) begin
        pl_addr = 4'(i);
        #1;
        check($sformatf("%s:pl[%0d]", tag, i), 32'(pl_data), 32'(m_pl[i]));
      end
    end
    check({tag, ":drop"},    32'(drop_count), 32'(m_drop));
    check({tag, ":n_chk"},   32'(mon_chk),    32'(e_chk));
    check({tag, ":n_len"},   32'(mon_len),    32'(e_len));
    check({tag, ":n_line"},  32'(mon_line),   32'(e_line));
    check({tag, ":n_tmo"},   32'(mon_tmo),    32'(e_tmo));
    check({tag, ":en_low"},  32'(mon_en_low), 32'(e_len + e_line + e_tmo));
  endtask

  // Build and send a frame; kind: 0 good, 1 bad checksum, 2 bad length,
  // 3 line error part-way through. The first byte may carry cmd_ack.
  task automatic send_frame(input int kind, input bit first_ack);
    logic [7:0] fq [$];
    logic [7:0] x;
    int n, k;
    n = $urandom_range(0, MAXP);
    fq.push_back(SOF);
    fq.push_back(8'($urandom));
    if (kind == 2) begin
      fq.push_back(8'($urandom_range(MAXP + 1, 255)));
    end else begin
      fq.push_back(8'(n));
      for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
      x = 8'h00;
      for (int i = 1; i < fq.size(); i++) x ^= fq[i];
      if (kind == 1) x ^= 8'($urandom_range(1, 255));
      fq.push_back(x);
    end
    k = (kind == 3) ? $urandom_range(1, fq.size() - 1) : fq.size();
    for (int i = 0; i < k; i++) send(fq[i], (i == 0) && first_ack);
    if (kind == 3) line_err();
  endtask

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int elapsed;
    int r;
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; rx_busy = 1'b0;
    rx_error = 1'b0; cmd_ack = 1'b0; pl_addr = '0;
    model_reset();
    idle(3);
    check("reset:rx_enable", 32'(rx_enable),  32'd0);
    check("reset:valid",     32'(cmd_valid),  32'd0);
    check("reset:code",      32'(cmd_code),   32'd0);
    check("reset:len",       32'(cmd_len),    32'd0);
    check("reset:drop",      32'(drop_count), 32'd0);
    check("reset:errs",      32'({err_chk, err_len, err_line, err_timeout}), 32'd0);
    rst_n = 1'b1;
    @(negedge baud);
    check("release:rx_enable", 32'(rx_enable), 32'd1);
    mon_on = 1'b1;

    // 1. Good frame
    send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h33, 0); send(8'h44, 0); send(8'h65, 0);
    check("good:code_const", 32'(cmd_code), 32'h10);
    check("good:len_const",  32'(cmd_len),  32'd2);
    verify("good");
    ack();
    verify("good_ack");

    // 2. Bad checksum
    send(8'hA5, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h33, 0); send(8'h44, 0); send(8'h66, 0);
    check("badchk:drop_const", 32'(drop_count), 32'd1);
    verify("badchk");

    // 3. Bad length then a good frame
    send(8'hA5, 0); send(8'h20, 0); send(8'h11, 0);
    verify("badlen");
    send(8'hA5, 0); send(8'h21, 0); send(8'h01, 0); send(8'h5A, 0);
    send(8'h21 ^ 8'h01 ^ 8'h5A, 0);
    verify("after_badlen");
    ack();

    // 4. Zero length
    send(8'hA5, 0); send(8'h07, 0); send(8'h00, 0); send(8'h07, 0);
    check("zero:len_const", 32'(cmd_len), 32'd0);
    verify("zero");
    ack();

    // 5. Timeout after A5 10
    send(8'hA5, 0);
    @(negedge baud);
    rx_data = 8'h10; rx_done = 1'b1;
    @(negedge baud);
    rx_done = 1'b0;
    model_byte(8'h10);
    elapsed = 1;
    while (elapsed < TMO + 50) begin
      @(negedge baud);
      elapsed++;
      if (err_timeout) break;
    end
    check("tmo:latency_in_window",
          32'((elapsed >= TMO - 2) && (elapsed <= TMO + 3)), 32'd1);
    model_abort(1'b0);
    idle(2);
    verify("tmo");

    // 6. Overrun while holding, then ack racing a SOF byte
    send_frame(0, 0);
    verify("ovr_first");
    if (!m_hold) send_frame(0, 0);
    send(8'hA5, 0); send(8'h11, 0); send(8'h00, 0); send(8'h11, 0);
    verify("ovr");
    send(8'hA5, 1); send(8'h30, 0); send(8'h01, 0); send(8'h77, 0);
    send(8'h30 ^ 8'h01 ^ 8'h77, 0);
    check("race:code_const", 32'(cmd_code), 32'h30);
    verify("race");
    line_err();
    verify("hold_line_ignored");
    ack();

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (m_hold) begin
        if (r < 45)      ack();
        else if (r < 75) send_frame($urandom_range(0, 3), 1);
        else             send(8'($urandom), 0);
      end else begin
        if (r < 45)      send_frame(0, 0);
        else if (r < 60) send_frame(1, 0);
        else if (r < 70) send_frame(2, 0);
        else if (r < 82) send_frame(3, 0);
        else if (r < 92) send(8'($urandom), 0);
        else             ack();
      end
      verify($sformatf("rand%0d", it));
    end

    // Drop counter saturation through overruns
    if (m_hold) ack();
    send(8'hA5, 0); send(8'h42, 0); send(8'h00, 0); send(8'h42, 0);
    for (int i = 0; i < 260; i++) send(8'($urandom), 0);
    check("sat:drop_const", 32'(drop_count), 32'hFF);
    verify("sat");

    // Asynchronous reset in the middle of a frame
    ack();
    send(8'hA5, 0); send(8'h10, 0);
    @(negedge baud);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midreset:drop",      32'(drop_count), 32'd0);
    check("midreset:rx_enable", 32'(rx_enable),  32'd0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    @(negedge baud);
    mon_on = 1'b1;
    send(8'h02, 0); send(8'h33, 0);   // stale tail of the old frame: ignored
    send_frame(0, 0);
    verify("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
